// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier, one product bit per clock.
// Define MULT_SEQ_OVF_EN to add the registered ovf output.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef MULT_SEQ_OVF_EN
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf
`else
  output logic [WIDTH-1:0] result_hi
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
`ifdef MULT_SEQ_OVF_EN
  logic             sgn_q, sgn_d;
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod;

  // The unit takes a new operation when idle or in its final cycle.
  assign accept = start && (state_q != S_RUN);

  // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // The low half of the accumulator doubles as the shifting multiplier.
  assign addend = acc_q[0] ? mcand_q : '0;
  assign sum    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
  assign prod   = neg_q ? -acc_q : acc_q;

  // Next-state, datapath and output-load decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef MULT_SEQ_OVF_EN
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        lo_d    = prod[WIDTH-1:0];
        hi_d    = prod[PW-1:WIDTH];
        done_d  = 1'b1;
`ifdef MULT_SEQ_OVF_EN
        if (sgn_q) begin
          ovf_d = prod[PW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end else begin
          ovf_d = |prod[PW-1:WIDTH];
        end
`endif
        state_d = start ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      mcand_d = a_mag;
      acc_d   = {{WIDTH{1'b0}}, b_mag};
      neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt_d   = '0;
`ifdef MULT_SEQ_OVF_EN
      sgn_d   = is_signed;
`endif
    end
  end

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef MULT_SEQ_OVF_EN
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef MULT_SEQ_OVF_EN
      sgn_q   <= sgn_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = lo_q;
  assign result_hi = hi_q;
`ifdef MULT_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: checks a 32-bit and an 8-bit mult_seq against a
// cycle-level arithmetic model plus hand-computed products.
module tb_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st0, sg0, st1, sg1;
  logic [31:0] a0, b0, lo0, hi0;
  logic [7:0]  a1, b1, lo1, hi1;
  logic        busy0, done0, busy1, done1;
`ifdef MULT_SEQ_OVF_EN
  logic        ovf0, ovf1;
`endif

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st0), .is_signed(sg0),
    .a(a0), .b(b0), .busy(busy0), .done(done0),
    .result(lo0),
`ifdef MULT_SEQ_OVF_EN
    .result_hi(hi0), .ovf(ovf0)
`else
    .result_hi(hi0)
`endif
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st1), .is_signed(sg1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .result(lo1),
`ifdef MULT_SEQ_OVF_EN
    .result_hi(hi1), .ovf(ovf1)
`else
    .result_hi(hi1)
`endif
  );

  int checks = 0;
  int fails  = 0;

  // literal expectation attached to the next accepted operation
  bit           nlv [2];
  logic [127:0] nlit[2];

  // product of two w-bit operands, reduced to 2w bits
  function automatic logic [127:0] mprod(input logic [63:0] x,
                                         input logic [63:0] y,
                                         input bit s, input int w);
    logic [127:0] ax, bx, m;
    m  = (128'd1 << (2 * w)) - 128'd1;
    ax = {64'b0, x};
    bx = {64'b0, y};
    if (s && x[w-1]) ax = ax - (128'd1 << w);
    if (s && y[w-1]) bx = bx - (128'd1 << w);
    return (ax * bx) & m;
  endfunction

`ifdef MULT_SEQ_OVF_EN
  function automatic bit ovf_of(input logic [127:0] p, input bit s,
                                input int w);
    logic [127:0] m, hi;
    m  = (128'd1 << w) - 128'd1;
    hi = (p >> w) & m;
    if (s) return hi != (p[w-1] ? m : 128'd0);
    return hi != 128'd0;
  endfunction
`endif

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model state per unit (0: 32-bit, 1: 8-bit)
  bit           p_rst;
  bit           p_st[2], p_sg[2], p_lv[2];
  logic [63:0]  p_a[2], p_b[2];
  logic [127:0] p_lit[2];
  int           m_left[2];
  bit           m_done[2], m_sg[2], m_psg[2], m_lv[2], m_plv[2];
  logic [127:0] m_res[2], m_pend[2], m_lit[2], m_plit[2];

  // Model steps for the edge just passed, then all outputs are compared.
  initial begin
    int w;
    bit can;
    p_rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      p_st[u] = 0; p_sg[u] = 0; p_lv[u] = 0;
      p_a[u] = 0; p_b[u] = 0; p_lit[u] = 0;
      m_left[u] = 0; m_done[u] = 0; m_sg[u] = 0; m_psg[u] = 0;
      m_lv[u] = 0; m_plv[u] = 0;
      m_res[u] = 0; m_pend[u] = 0; m_lit[u] = 0; m_plit[u] = 0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        w = (u == 0) ? 32 : 8;
        if (p_rst) begin
          m_left[u] = 0;
          m_done[u] = 0;
          m_res[u]  = 0;
          m_lv[u]   = 0;
        end else begin
          can = (m_left[u] <= 1);
          m_done[u] = 0;
          if (m_left[u] > 0) begin
            m_left[u]--;
            if (m_left[u] == 0) begin
              m_done[u] = 1;
              m_res[u]  = m_pend[u];
              m_sg[u]   = m_psg[u];
              m_lv[u]   = m_plv[u];
              m_lit[u]  = m_plit[u];
            end
          end
          if (p_st[u] && can) begin
            m_left[u] = w + 1;
            m_pend[u] = mprod(p_a[u], p_b[u], p_sg[u], w);
            m_psg[u]  = p_sg[u];
            m_plv[u]  = p_lv[u];
            m_plit[u] = p_lit[u];
          end
        end
      end

      chk("busy32", busy0, m_left[0] != 0);
      chk("done32", done0, m_done[0]);
      chk("prod32", {hi0, lo0}, m_res[0][63:0]);
      chk("busy8", busy1, m_left[1] != 0);
      chk("done8", done1, m_done[1]);
      chk("prod8", {hi1, lo1}, m_res[1][15:0]);
`ifdef MULT_SEQ_OVF_EN
      chk("ovf32", ovf0, ovf_of(m_res[0], m_sg[0], 32));
      chk("ovf8", ovf1, ovf_of(m_res[1], m_sg[1], 8));
`endif
      if (m_done[0] && m_lv[0]) chk("lit32", {hi0, lo0}, m_lit[0][63:0]);
      if (m_done[1] && m_lv[1]) chk("lit8", {hi1, lo1}, m_lit[1][15:0]);

      p_rst   = rst;
      p_st[0] = st0; p_sg[0] = sg0;
      p_a[0]  = {32'b0, a0}; p_b[0] = {32'b0, b0};
      p_lv[0] = nlv[0]; p_lit[0] = nlit[0];
      p_st[1] = st1; p_sg[1] = sg1;
      p_a[1]  = {56'b0, a1}; p_b[1] = {56'b0, b1};
      p_lv[1] = nlv[1]; p_lit[1] = nlit[1];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] r8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic go0(input bit s, input logic [31:0] x, input logic [31:0] y,
                     input bit lv, input logic [63:0] lit);
    sg0 = s; a0 = x; b0 = y; st0 = 1'b1;
    nlv[0] = lv; nlit[0] = {64'b0, lit};
    cyc(1);
    st0 = 1'b0; nlv[0] = 1'b0;
    a0 = $urandom; b0 = $urandom; sg0 = 1'($urandom_range(0, 1));
  endtask

  task automatic go1(input bit s, input logic [7:0] x, input logic [7:0] y,
                     input bit lv, input logic [15:0] lit);
    sg1 = s; a1 = x; b1 = y; st1 = 1'b1;
    nlv[1] = lv; nlit[1] = {112'b0, lit};
    cyc(1);
    st1 = 1'b0; nlv[1] = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); sg1 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1;
    st0 = 0; sg0 = 0; a0 = 0; b0 = 0;
    st1 = 0; sg1 = 0; a1 = 0; b1 = 0;
    nlv[0] = 0; nlv[1] = 0; nlit[0] = 0; nlit[1] = 0;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    go0(1, 32'd39474, 32'd40392, 1, 64'd1594433808);
    cyc(33);
    go0(1, 32'd25, 32'd520843, 1, 64'd13021075);
    cyc(33);

    // back-to-back with start held through the whole first operation
    sg0 = 1; a0 = -32'd3348; b0 = 32'd3294; st0 = 1;
    nlv[0] = 1; nlit[0] = {64'b0, 64'hFFFF_FFFF_FF57_B8A8};
    cyc(1);
    a0 = 32'd3294; b0 = -32'd3348;
    cyc(33);
    st0 = 0; nlv[0] = 0;
    cyc(33);

    go0(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    cyc(33);
    go0(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h1);
    cyc(33);
    go0(1, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000);
    cyc(33);

    // stray start mid-run, operand changed after capture
    go0(1, -32'd45598, -32'd342, 1, 64'd15594516);
    cyc(9);
    a0 = 32'd7; st0 = 1;
    cyc(1);
    st0 = 0;
    cyc(23);

    // reset in the middle of a run
    go0(0, 32'd1, 32'd2, 1, 64'd2);
    cyc(14);
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(2);
    go0(0, 32'd1, 32'd0, 1, 64'd0);
    cyc(33);

    go1(1, 8'h80, 8'h80, 1, 16'h4000);
    cyc(9);
    go1(0, 8'd200, 8'd3, 1, 16'h0258);
    cyc(9);

    for (int i = 0; i < 150; i++) begin
      go0(1'($urandom_range(0, 1)), r32(), r32(), 0, 64'd0);
      cyc($urandom_range(28, 35));
    end
    cyc(40);
    for (int i = 0; i < 300; i++) begin
      go1(1'($urandom_range(0, 1)), r8(), r8(), 0, 16'd0);
      cyc($urandom_range(4, 11));
    end
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
